// File: rtl/chunk_stream_checker_if.sv
// Sample/result bundle between the chunk producer and chunk_stream_checker.
// master drives enable/data, slave returns the serial stream and status.
interface chunk_stream_checker_if #(
  parameter int CHUNKS = 5
);
  logic        enable;
  logic [10:0] data [CHUNKS];
  logic        bit_out;
  logic        bit_valid;
  logic        locked;
  logic        error;
  logic [15:0] err_count;
  logic [31:0] bit_count;

  modport master (
    output enable,
    output data,
    input  bit_out,
    input  bit_valid,
    input  locked,
    input  error,
    input  err_count,
    input  bit_count
  );

  modport slave (
    input  enable,
    input  data,
    output bit_out,
    output bit_valid,
    output locked,
    output error,
    output err_count,
    output bit_count
  );
endinterface

// File: rtl/chunk_stream_checker.sv
// Checks a chunked shift-left/toggle-LSB stream and re-serialises its MSB.
// Define CHUNK_CHECK_TOGGLE_EN to also require the LSB to toggle.
module chunk_stream_checker #(
  parameter int CHUNKS     = 5,
  parameter int LOCK_COUNT = 4,
  parameter int LOSS_LIMIT = 3
) (
  input logic             clock,
  input logic             reset_n,
  chunk_stream_checker_if.slave bus
);

  localparam int W  = CHUNKS * 11;
  localparam int GW = $clog2(LOCK_COUNT + 1);
  localparam int MW = $clog2(LOSS_LIMIT + 1);

  typedef enum logic [1:0] {
    IDLE,
    PRIME,
    LOCKED,
    LOST
  } state_e;

  state_e         state_q;
  logic [W-1:0]   f_w;
  logic [W-1:0]   prev_q;
  logic           match_w;
  logic [GW-1:0]  good_q;
  logic [GW-1:0]  good_d;
  logic [MW-1:0]  miss_q;
  logic [MW-1:0]  miss_d;
  logic           bit_out_q;
  logic           bit_valid_q;
  logic           locked_q;
  logic           error_q;
  logic [15:0]    err_count_q;
  logic [15:0]    err_count_d;
  logic [31:0]    bit_count_q;

  always_comb begin
    f_w = '0;
    for (int i = 0; i < CHUNKS; i++) begin
      f_w[i*11 +: 11] = bus.data[i];
    end
  end

`ifdef CHUNK_CHECK_TOGGLE_EN
  assign match_w = (f_w == {prev_q[W-2:0], ~prev_q[0]});
`else
  // LSB is free: only the shifted body must line up
  assign match_w = (f_w[W-1:1] == prev_q[W-2:0]);
`endif

  assign good_d      = good_q + 1'b1;
  assign miss_d      = miss_q + 1'b1;
  assign err_count_d = (&err_count_q) ? err_count_q
                                      : err_count_q + 16'd1;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      prev_q      <= '0;
      good_q      <= '0;
      miss_q      <= '0;
      bit_out_q   <= 1'b0;
      bit_valid_q <= 1'b0;
      locked_q    <= 1'b0;
      error_q     <= 1'b0;
      err_count_q <= '0;
      bit_count_q <= '0;
    end else begin
      error_q     <= 1'b0;
      bit_valid_q <= 1'b0;
      if (!bus.enable) begin
        state_q  <= IDLE;
        locked_q <= 1'b0;
      end else begin
        unique case (state_q)
          IDLE: begin
            prev_q  <= f_w;
            good_q  <= '0;
            state_q <= PRIME;
          end
          PRIME: begin
            prev_q <= f_w;
            if (match_w) begin
              good_q <= good_d;
              if (good_d == GW'(LOCK_COUNT)) begin
                state_q  <= LOCKED;
                locked_q <= 1'b1;
                miss_q   <= '0;
              end
            end else begin
              good_q <= '0;
            end
          end
          LOCKED: begin
            prev_q <= f_w;
            if (match_w) begin
              bit_valid_q <= 1'b1;
              bit_out_q   <= prev_q[W-1];
              bit_count_q <= bit_count_q + 32'd1;
              miss_q      <= '0;
            end else begin
              error_q     <= 1'b1;
              err_count_q <= err_count_d;
              miss_q      <= miss_d;
              if (miss_d == MW'(LOSS_LIMIT)) begin
                state_q  <= LOST;
                locked_q <= 1'b0;
              end
            end
          end
          LOST: begin
            prev_q   <= f_w;
            good_q   <= '0;
            locked_q <= 1'b0;
            state_q  <= PRIME;
          end
          default: begin
            state_q  <= IDLE;
            locked_q <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.bit_out   = bit_out_q;
  assign bus.bit_valid = bit_valid_q;
  assign bus.locked    = locked_q;
  assign bus.error     = error_q;
  assign bus.err_count = err_count_q;
  assign bus.bit_count = bit_count_q;

endmodule

// File: tb/tb_chunk_stream_checker.sv
// Randomised bench for chunk_stream_checker against a sample-level model.
// Models the stream as 64-bit integers with plain shift arithmetic.
module tb_chunk_stream_checker;

  localparam int CHUNKS = 5;
  localparam int LC     = 4;
  localparam int LL     = 3;
  localparam int W      = CHUNKS * 11;
  localparam longint unsigned MASK = (64'd1 << W) - 64'd1;

  localparam int M_IDLE   = 0;
  localparam int M_PRIME  = 1;
  localparam int M_LOCKED = 2;
  localparam int M_LOST   = 3;

  logic clock;
  logic reset_n;

  chunk_stream_checker_if #(.CHUNKS(CHUNKS)) bus ();

  chunk_stream_checker #(
    .CHUNKS    (CHUNKS),
    .LOCK_COUNT(LC),
    .LOSS_LIMIT(LL)
  ) dut (
    .clock  (clock),
    .reset_n(reset_n),
    .bus    (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_tests;
  int n_fail;

  int              m_mode;
  longint unsigned m_prev;
  int              m_good;
  int              m_miss;
  bit              e_lk, e_er, e_bv, e_bo;
  int unsigned     e_ec, e_bc;

  function automatic logic [51:0] obs();
    return {bus.locked, bus.error, bus.bit_valid,
            bus.bit_valid & bus.bit_out,
            bus.err_count, bus.bit_count};
  endfunction

  function automatic logic [51:0] expv();
    return {e_lk, e_er, e_bv, e_bv & e_bo,
            e_ec[15:0], e_bc};
  endfunction

  function automatic longint unsigned nxt(longint unsigned p);
    return ((p << 1) | (~p & 64'd1)) & MASK;
  endfunction

  function automatic bit sample_ok(longint unsigned p,
                                   longint unsigned f);
`ifdef CHUNK_CHECK_TOGGLE_EN
    return f == nxt(p);
`else
    return (f >> 1) == (p & (MASK >> 1));
`endif
  endfunction

  function automatic longint unsigned good_of(longint unsigned p);
`ifdef CHUNK_CHECK_TOGGLE_EN
    return nxt(p);
`else
    return nxt(p) ^ longint'($urandom_range(1, 0));
`endif
  endfunction

  function automatic longint unsigned bad_of(longint unsigned p);
    return nxt(p) ^ (64'd1 << $urandom_range(W - 1, 1));
  endfunction

  function automatic longint unsigned rnd_w();
    return {$urandom, $urandom} & MASK;
  endfunction

  task automatic model_reset();
    m_mode = M_IDLE;
    m_prev = 0;
    m_good = 0;
    m_miss = 0;
    e_lk = 0; e_er = 0; e_bv = 0; e_bo = 0;
    e_ec = 0; e_bc = 0;
  endtask

  task automatic model_step(bit en, longint unsigned f);
    bit ok;
    ok   = sample_ok(m_prev, f);
    e_er = 0;
    e_bv = 0;
    if (!en) begin
      m_mode = M_IDLE;
      e_lk   = 0;
    end else if (m_mode == M_IDLE) begin
      m_prev = f; m_good = 0; m_mode = M_PRIME;
    end else if (m_mode == M_PRIME) begin
      m_good = ok ? m_good + 1 : 0;
      m_prev = f;
      if (m_good == LC) begin
        m_mode = M_LOCKED; m_miss = 0; e_lk = 1;
      end
    end else if (m_mode == M_LOCKED) begin
      if (ok) begin
        e_bv = 1;
        e_bo = bit'((m_prev >> (W - 1)) & 64'd1);
        e_bc = e_bc + 1;
        m_miss = 0;
      end else begin
        e_er = 1;
        if (e_ec < 16'hFFFF) e_ec = e_ec + 1;
        m_miss = m_miss + 1;
        if (m_miss == LL) begin
          m_mode = M_LOST; e_lk = 0;
        end
      end
      m_prev = f;
    end else begin
      m_prev = f; m_good = 0; m_mode = M_PRIME; e_lk = 0;
    end
  endtask

  task automatic drive(bit en, longint unsigned f);
    logic [W-1:0] fv;
    fv = f[W-1:0];
    bus.enable = en;
    for (int i = 0; i < CHUNKS; i++) bus.data[i] = fv[i*11 +: 11];
    @(posedge clock);
    model_step(en, f);
    #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    bus.enable = 1'b0;
    for (int i = 0; i < CHUNKS; i++) bus.data[i] = '0;
    model_reset();
    @(negedge clock);
    @(negedge clock);
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    n_tests++;
    if (obs() !== 52'd0) begin
      n_fail++;
      $display("FAIL reset_state: got %h want 0", obs());
    end
  endtask

  task automatic test_lock_sequence();
    longint unsigned seq [8] = '{0, 1, 2, 5, 10, 21, 42, 85};
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, seq[i]);
      n_tests++;
      if (obs() !== expv()) begin
        n_fail++;
        $display("FAIL lock_seq[%0d]: got %h want %h", i, obs(), expv());
      end
      if (i == 4) begin
        n_tests++;
        if (bus.locked !== 1'b1) begin
          n_fail++;
          $display("FAIL lock_on_5th: got %b want 1", bus.locked);
        end
      end
      if (i == 5) begin
        n_tests++;
        if ({bus.bit_valid, bus.bit_out, bus.bit_count} !== {2'b10, 32'd1}) begin
          n_fail++;
          $display("FAIL first_bit: got v=%b b=%b c=%0d want v=1 b=0 c=1",
                   bus.bit_valid, bus.bit_out, bus.bit_count);
        end
      end
    end
  endtask

  task automatic test_single_error();
    drive(1'b1, 0);
    n_tests++;
    if ({bus.error, bus.locked, bus.err_count} !== {2'b11, 16'd1}) begin
      n_fail++;
      $display("FAIL single_err: got e=%b l=%b ec=%0d want e=1 l=1 ec=1",
               bus.error, bus.locked, bus.err_count);
    end
    drive(1'b1, good_of(m_prev));
    n_tests++;
    if (obs() !== expv() || bus.error !== 1'b0) begin
      n_fail++;
      $display("FAIL err_pulse_end: got %h want %h", obs(), expv());
    end
  endtask

  task automatic test_loss_relock();
    int unsigned ec0;
    ec0 = e_ec;
    for (int i = 0; i < LL; i++) drive(1'b1, bad_of(m_prev));
    n_tests++;
    if ({bus.locked, bus.err_count} !== {1'b0, 16'(ec0 + LL)}) begin
      n_fail++;
      $display("FAIL loss: got l=%b ec=%0d want l=0 ec=%0d",
               bus.locked, bus.err_count, ec0 + LL);
    end
    for (int i = 0; i < 1 + LC + 2; i++) begin
      drive(1'b1, good_of(m_prev));
      n_tests++;
      if (obs() !== expv()) begin
        n_fail++;
        $display("FAIL relock[%0d]: got %h want %h", i, obs(), expv());
      end
    end
    n_tests++;
    if (bus.locked !== 1'b1) begin
      n_fail++;
      $display("FAIL relock_final: got %b want 1", bus.locked);
    end
  endtask

  task automatic test_msb_stream();
    longint unsigned lockprev;
    int k;
    drive(1'b0, 0);
    drive(1'b1, rnd_w() | (64'h1F << (W - 5)));
    for (int i = 0; i < LC; i++) drive(1'b1, good_of(m_prev));
    lockprev = m_prev;
    k = 0;
    for (int i = 0; i < W + 10; i++) begin
      drive(1'b1, good_of(m_prev));
      n_tests++;
      if (obs() !== expv()) begin
        n_fail++;
        $display("FAIL msb_stream[%0d]: got %h want %h", i, obs(), expv());
      end
      if (k < W) begin
        n_tests++;
        if (bus.bit_valid !== 1'b1 ||
            bus.bit_out !== lockprev[W-1-k]) begin
          n_fail++;
          $display("FAIL msb_bit[%0d]: got v=%b b=%b want v=1 b=%b",
                   k, bus.bit_valid, bus.bit_out, lockprev[W-1-k]);
        end
        k++;
      end
    end
  endtask

  task automatic test_enable_drop();
    drive(1'b0, good_of(m_prev));
    n_tests++;
    if (obs() !== expv() || bus.locked !== 1'b0) begin
      n_fail++;
      $display("FAIL en_drop: got %h want %h", obs(), expv());
    end
    drive(1'b1, rnd_w());
    drive(1'b1, good_of(m_prev));
    #2;
    reset_n = 1'b0;
    model_reset();
    #1;
    n_tests++;
    if (obs() !== 52'd0) begin
      n_fail++;
      $display("FAIL async_reset: got %h want 0", obs());
    end
    @(negedge clock);
    reset_n = 1'b1;
  endtask

  task automatic test_lsb_no_toggle();
    longint unsigned f;
    f = 3;
    drive(1'b1, f);
    for (int i = 0; i < 10; i++) begin
      f = (f << 1) & MASK;
      drive(1'b1, f);
      n_tests++;
      if (obs() !== expv()) begin
        n_fail++;
        $display("FAIL lsb[%0d]: got %h want %h", i, obs(), expv());
      end
    end
    n_tests++;
`ifdef CHUNK_CHECK_TOGGLE_EN
    if ({bus.locked, bus.err_count} !== {1'b0, 16'd0}) begin
      n_fail++;
      $display("FAIL lsb_final: got l=%b ec=%0d want l=0 ec=0",
               bus.locked, bus.err_count);
    end
`else
    if ({bus.locked, bus.err_count} !== {1'b1, 16'd0}) begin
      n_fail++;
      $display("FAIL lsb_final: got l=%b ec=%0d want l=1 ec=0",
               bus.locked, bus.err_count);
    end
`endif
  endtask

  task automatic test_random();
    bit en;
    longint unsigned f;
    for (int i = 0; i < 400; i++) begin
      en = ($urandom_range(19, 0) != 0);
      if ($urandom_range(99, 0) < 85) f = good_of(m_prev);
      else if ($urandom_range(1, 0) == 1) f = bad_of(m_prev);
      else f = rnd_w();
      drive(en, f);
      n_tests++;
      if (obs() !== expv()) begin
        n_fail++;
        $display("FAIL random[%0d]: got %h want %h", i, obs(), expv());
      end
    end
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    test_reset();
    test_lock_sequence();
    test_single_error();
    test_loss_relock();
    test_msb_stream();
    test_enable_drop();
    test_lsb_no_toggle();
    do_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
